// File: rtl/sched_arbiter_rr.sv
// sched_arbiter_rr: N-channel round-robin request arbiter with read/write
// mode grouping, a run-length cap per mode, and a registered valid/ready
// output stage.
//
// Handshake: a channel transfer happens on valid_i[c] & ready_o[c]; the output
// transfer happens on out_valid & out_ready. ready_o is combinational, at most
// one-hot, and zero whenever the output register cannot load. Once out_valid
// is high, the output fields hold until out_ready is seen.
module sched_arbiter_rr #(
  parameter int NUM_CH  = 16,
  parameter int IDX     = 6,
  parameter int RA      = 16,
  parameter int CA      = 10,
  parameter int DQ      = 16,
  parameter int MAX_RUN = 8,
  localparam int CHW    = $clog2(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH-1:0]    valid_i,
  output logic [NUM_CH-1:0]    ready_o,
  input  logic [NUM_CH*DQ-1:0] data_i,
  input  logic [NUM_CH*IDX-1:0] idx_i,
  input  logic [NUM_CH*RA-1:0] row_i,
  input  logic [NUM_CH*CA-1:0] col_i,
  input  logic [NUM_CH-1:0]    t_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DQ-1:0]        data_o,
  output logic [IDX-1:0]       idx_o,
  output logic [RA-1:0]        row_o,
  output logic [CA-1:0]        col_o,
  output logic                 t_o,
  output logic [CHW-1:0]       ch_o,
  output logic                 mode_o
);

  localparam int RCW = $clog2(MAX_RUN + 1);

  // The arbitration mode is the only state machine; it is exposed on mode_o.
  typedef enum logic {MODE_RD = 1'b0, MODE_WR = 1'b1} mode_t;

  mode_t          r_mode;
  logic [CHW-1:0] r_ptr_rd;
  logic [CHW-1:0] r_ptr_wr;
  logic [RCW-1:0] r_run_cnt;

  logic           r_out_valid;
  logic [DQ-1:0]  r_data;
  logic [IDX-1:0] r_idx;
  logic [RA-1:0]  r_row;
  logic [CA-1:0]  r_col;
  logic           r_t;
  logic [CHW-1:0] r_ch;

  logic [NUM_CH-1:0] w_elig;
  logic              w_other;
  logic              w_switch;
  logic              w_load;
  logic              w_grant;
  logic [CHW-1:0]    w_ptr_cur;
  logic [CHW-1:0]    w_gnt_ch;
  logic [CHW-1:0]    w_ptr_next;
  logic              w_run_full;

  // First requesting channel at or above ptr, wrapping NUM_CH-1 -> 0.
  function automatic logic [CHW-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                             input logic [CHW-1:0] ptr);
    logic [CHW-1:0] pick;
    logic           hit;
    int             c;
    pick = '0;
    hit  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      c = int'(ptr) + i;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (!hit && req[c]) begin
        hit  = 1'b1;
        pick = c[CHW-1:0];
      end
    end
    return pick;
  endfunction

  // Eligibility, mode-switch decision and grant selection.
  always_comb begin
    w_elig     = valid_i & ((r_mode == MODE_WR) ? t_i : ~t_i);
    w_other    = |(valid_i & ((r_mode == MODE_WR) ? ~t_i : t_i));
    w_run_full = (r_run_cnt == RCW'(MAX_RUN));
    w_switch   = w_other && ((w_elig == '0) || w_run_full);
    w_load     = !r_out_valid || out_ready;
    w_grant    = !w_switch && (w_elig != '0) && w_load;
    w_ptr_cur  = (r_mode == MODE_WR) ? r_ptr_wr : r_ptr_rd;
    w_gnt_ch   = rr_pick(w_elig, w_ptr_cur);
    w_ptr_next = (int'(w_gnt_ch) == NUM_CH - 1) ? '0 : w_gnt_ch + 1'b1;
    ready_o    = '0;
    if (w_grant) ready_o[w_gnt_ch] = 1'b1;
  end

  // Mode, pointers and run counter; a switch cycle grants nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode    <= MODE_RD;
      r_ptr_rd  <= '0;
      r_ptr_wr  <= '0;
      r_run_cnt <= '0;
    end else if (w_switch) begin
      r_mode    <= (r_mode == MODE_RD) ? MODE_WR : MODE_RD;
      r_run_cnt <= '0;
    end else if (w_grant) begin
      if (r_mode == MODE_WR) r_ptr_wr <= w_ptr_next;
      else                   r_ptr_rd <= w_ptr_next;
      if (!w_run_full) r_run_cnt <= r_run_cnt + 1'b1;
    end
  end

  // Output register: load on grant, drain on out_ready, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_data      <= '0;
      r_idx       <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_t         <= 1'b0;
      r_ch        <= '0;
    end else if (w_grant) begin
      r_out_valid <= 1'b1;
      r_data      <= data_i[w_gnt_ch*DQ +: DQ];
      r_idx       <= idx_i[w_gnt_ch*IDX +: IDX];
      r_row       <= row_i[w_gnt_ch*RA +: RA];
      r_col       <= col_i[w_gnt_ch*CA +: CA];
      r_t         <= t_i[w_gnt_ch];
      r_ch        <= w_gnt_ch;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign data_o    = r_data;
  assign idx_o     = r_idx;
  assign row_o     = r_row;
  assign col_o     = r_col;
  assign t_o       = r_t;
  assign ch_o      = r_ch;
  assign mode_o    = r_mode;

endmodule

// File: doc/sched_arbiter_rr.md
# sched_arbiter_rr

Parametrised N-channel request arbiter between the per-bank schedulers and the burst handler in the memory-controller back end. It generalises the fixed 16-input arbiter in three ways:

- configurable channel count;
- read/write mode grouping with a run-length cap;
- registered valid/ready output with backpressure, in place of a bare write enable.

Each cycle it grants at most one request. Grants are round-robin within the current mode.

## Interface
Parameters:
- NUM_CH, 16, number of scheduler channels (≥2); CHW = $clog2(NUM_CH)
- IDX, 6, request index width
- RA, 16, row address width
- CA, 10, column address width
- DQ, 16, data width
- MAX_RUN, 8, maximum consecutive grants of one type while the other type is pending (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- valid_i  in  NUM_CH  per-channel request valid
- ready_o  out  NUM_CH  per-channel accept, one-hot or zero
- data_i  in  NUM_CH*DQ  channel c at [c*DQ +: DQ]
- idx_i  in  NUM_CH*IDX  packed the same way
- row_i  in  NUM_CH*RA  packed the same way
- col_i  in  NUM_CH*CA  packed the same way
- t_i  in  NUM_CH  request type: 0 = read, 1 = write
- out_valid  out  1  output register holds a request
- out_ready  in  1  burst handler accepts the output
- data_o  out  DQ  granted data
- idx_o  out  IDX  granted index
- row_o  out  RA  granted row
- col_o  out  CA  granted column
- t_o  out  1  granted type
- ch_o  out  CHW  granted channel number; the bank and bank group are derived from this downstream
- mode_o  out  1  current arbitration mode: 0 = read, 1 = write

## Operation
- **Channel transfer.** A transfer on channel c occurs when valid_i[c] & ready_o[c].
- **ready_o.**
  - Combinational from valid_i, t_i and the internal state.
  - Never more than one bit set.
  - Zero in any cycle where the output register cannot load.
- **Load condition.** The output register may load when !out_valid | out_ready.
- **Eligible set.** E = valid_i & (t_i == mode).
- **Pending other type.** P_other = |(valid_i & (t_i != mode)).
- **Mode switch.**
  - The mode toggles in a cycle where either:
    - E is empty and P_other is set; or
    - run_cnt == MAX_RUN and P_other is set.
  - A switch cycle grants nothing: a one-cycle bubble.
  - A switch clears run_cnt to 0.
- **Grant.**
  - Occurs when not switching, E is non-empty and the load condition holds.
  - Grant g is the first channel of E searched upward from ptr[mode], wrapping NUM_CH-1 → 0.
  - On a grant:
    - ptr[mode] ← (g+1) mod NUM_CH;
    - run_cnt ← min(run_cnt+1, MAX_RUN);
    - the output register loads channel g's fields, t_o and ch_o = g.
- **Pointers.** Separate read and write pointers. The pointer of the inactive mode is untouched.
- **Output register.**
  - out_valid is set on a grant.
  - out_valid is cleared when out_ready is high and there is no new grant.
  - While out_valid & !out_ready, all outputs hold stable.
- **Reset state.** out_valid=0, data_o/idx_o/row_o/col_o/t_o/ch_o=0, mode_o=0 (read), both pointers 0, run_cnt 0.
- **Reset mid-operation.** An asserted rst immediately forces the reset state. The held request is discarded; the scheduler still owns retransmission, because no ready was issued for it after the original transfer.

## Timing
- **Latency.** Grant in cycle N; out_valid and the fields are visible from cycle N+1.
- **Throughput.** One request per cycle with out_ready held high. A grant in the same cycle as an output drain is allowed.
- **Mode switch.** Exactly one idle cycle between the last grant of the old mode and the first grant of the new mode.
- **MAX_RUN.** With both types pending continuously, grant pattern is MAX_RUN of one type, a bubble, then MAX_RUN of the other.
- **Single type only.** With only one type pending, run_cnt saturates and no switch occurs.
- **Width.** Pointer and ch_o arithmetic is mod NUM_CH. This holds for non-power-of-2 NUM_CH: ptr = NUM_CH-1 wraps to 0.

## Test plan
1. **Reset.** Reset asserted → all outputs 0, ready_o=0. Release, channel 3 read valid with row 0x1234 → ready_o=0x0008 that cycle; next cycle out_valid=1, ch_o=3, row_o=0x1234, t_o=0.
2. **Round-robin.** Reads held valid on channels 2, 5 and 15, out_ready=1 → grant order 2, 5, 15, 2, … one per cycle. Pointer wraps from 15 to 0.
3. **Backpressure.** out_ready=0 with out_valid=1 and channels 1 and 4 valid → ready_o=0 and outputs stable for 5 cycles. Raise out_ready → channel 1 granted the same cycle, out_valid stays 1.
4. **Mode cap.** MAX_RUN=2, reads on channels 0 and 1, write on channel 7, all held → R0, R1, bubble, W7, W7, bubble, R0. mode_o toggles at each bubble.
5. **Empty mode switch.** Only write on channel 9, mode read → one bubble cycle with mode_o→1, then grant channel 9 with t_o=1.
6. **Async reset mid-stream.** rst pulsed asynchronously mid-stream while out_valid=1 → out_valid falls without a clock edge. After release, the first grant starts from channel 0 in read mode.
